// File: rtl/db15_pkg.sv
// Shared types and constants for the DB15 two-player serial pad reader.
// Frames are 32 raw active-low bits: player 1 in [15:0], player 2 in [31:16].
package db15_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        DONE     = 3'd4
    } db15_state_e;

    localparam int FRAME_BITS = 32;
    localparam int PAD_BITS   = 16;

    localparam int BIT_R = 0;
    localparam int BIT_L = 1;
    localparam int BIT_D = 2;
    localparam int BIT_U = 3;

    // Active-high button word of one player (0 or 1) out of an active-low raw frame.
    function automatic logic [PAD_BITS-1:0] pad_of(input logic [FRAME_BITS-1:0] frame,
                                                   input int player);
        return ~frame[player*PAD_BITS +: PAD_BITS];
    endfunction

endpackage

// File: rtl/db15_tick_gen.sv
// Protocol prescaler: a registered one-clk tick every CLK_DIV clocks (CLK_DIV >= 4).
module db15_tick_gen #(
    parameter int CLK_DIV = 24
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    // Counter 0..CLK_DIV-1; tick_q is high exactly while the count sits at CLK_DIV-1.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            tick_q <= (cnt_q == CW'(CLK_DIV - 2));
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/db15_serial_reader.sv
// Polls a daisy-chained 74HC165 DB15 adapter and publishes two debounced
// active-high 16-bit button words, one per player.
module db15_serial_reader
    import db15_pkg::*;
#(
    parameter int CLK_DIV    = 24,
    parameter int POLL_TICKS = 1000,
    parameter int DEBOUNCE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        joy_data,
    output logic        joy_clk,
    output logic        joy_load,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_done
);

    localparam int IW = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;

    db15_state_e           state_q;
    logic [IW-1:0]         idle_cnt_q;
    logic [4:0]            bit_idx_q;
    logic [FRAME_BITS-1:0] raw_q;
    logic [FRAME_BITS-1:0] prev_q;
    logic [PAD_BITS-1:0]   joystick1_q;
    logic [PAD_BITS-1:0]   joystick2_q;
    logic                  joy_clk_q;
    logic                  joy_load_q;
    logic                  frame_done_q;
    logic                  data_meta_q;
    logic                  data_sync_q;
    logic                  tick_s;
    logic                  publish_s;

    db15_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i   (clk),
        .reset_i (reset),
        .tick_o  (tick_s)
    );

    // Two-stage synchronizer for the asynchronous adapter data line (idles high).
    always_ff @(posedge clk) begin
        if (reset) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= joy_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign publish_s = (DEBOUNCE == 0) || (raw_q == prev_q);

    // Frame sequencer: load strobe, 32 shift clocks, then a one-clk publish step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idle_cnt_q   <= IW'(POLL_TICKS - 1);
            bit_idx_q    <= 5'd0;
            raw_q        <= '1;
            prev_q       <= '1;
            joystick1_q  <= '0;
            joystick2_q  <= '0;
            joy_clk_q    <= 1'b0;
            joy_load_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    joy_load_q <= 1'b1;
                    joy_clk_q  <= 1'b0;
                    if (tick_s && enable) begin
                        if (idle_cnt_q == IW'(POLL_TICKS - 1)) begin
                            idle_cnt_q <= '0;
                            joy_load_q <= 1'b0;
                            state_q    <= LOAD;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (tick_s) begin
                        joy_load_q <= 1'b1;
                        bit_idx_q  <= 5'd0;
                        state_q    <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (tick_s) begin
                        raw_q[bit_idx_q] <= data_sync_q;
                        joy_clk_q        <= 1'b1;
                        state_q          <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick_s) begin
                        joy_clk_q <= 1'b0;
                        if (bit_idx_q == 5'd31) begin
                            state_q <= DONE;
                        end else begin
                            bit_idx_q <= bit_idx_q + 5'd1;
                            state_q   <= SHIFT_LO;
                        end
                    end
                end
                DONE: begin
                    // Both players update together so the mux never sees a half-new frame.
                    frame_done_q <= 1'b1;
                    if (publish_s) begin
                        joystick1_q <= pad_of(raw_q, 0);
                        joystick2_q <= pad_of(raw_q, 1);
                    end
                    prev_q     <= raw_q;
                    idle_cnt_q <= '0;
                    state_q    <= IDLE;
                end
                default: begin
                    joy_clk_q  <= 1'b0;
                    joy_load_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign joy_clk    = joy_clk_q;
    assign joy_load   = joy_load_q;
    assign joystick1  = joystick1_q;
    assign joystick2  = joystick2_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/db15_serial_reader.md
Name: db15_serial_reader

Overview:
- Upstream input stage for the arcade top level. Polls a two-player DB15 adapter (daisy-chained 74HC165 shift registers) over the UserIO port using a load/clock/data serial protocol.
- Delivers two debounced 16-bit active-high button words. Bit layout: [3:0]=R,L,D,U; [15:4]=buttons/start/select/coin.
- These words feed the top-level joystick mux and the OSD/raw-joystick paths.

Parameters:
- CLK_DIV, 24: clk cycles per protocol tick. Must be >= 4. At 48 MHz this gives a 2 MHz tick.
- POLL_TICKS, 1000: idle ticks between frames (~0.5 ms at default).
- DEBOUNCE, 1: 1 = publish a frame only when it equals the previous raw frame; 0 = publish every frame.

Ports:
- clk  in  1: system clock (40–50 MHz).
- reset  in  1: synchronous, active-high.
- enable  in  1: 1 = polling allowed; 0 = finish the current frame, then park in IDLE.
- joy_data  in  1: serial data from the adapter, active-low buttons, asynchronous.
- joy_clk  out  1: shift clock to the adapter. Idles low; the adapter shifts on the rising edge.
- joy_load  out  1: parallel-load strobe, active-low.
- joystick1  out  16: player 1 buttons, active-high.
- joystick2  out  16: player 2 buttons, active-high.
- frame_done  out  1: one-clk pulse when a frame completes, whether or not it is published.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values: joy_clk=0, joy_load=1, joystick1=0, joystick2=0, frame_done=0. Shift register and previous-frame register clear to all 1s. Prescaler=0. State=IDLE with the idle counter preloaded so LOAD begins on the first tick after reset deasserts.
- Reset mid-frame: the frame is abandoned immediately and outputs return to their reset values.
- Input sync: joy_data passes through a 2-FF synchronizer before use.
- Tick: the prescaler counts 0..CLK_DIV-1. Tick asserts for one clk when count==CLK_DIV-1, then wraps to 0. All state transitions happen only on tick.
- IDLE: joy_load=1, joy_clk=0.
  - If enable=1: count POLL_TICKS ticks, then go to LOAD.
  - If enable=0: the counter holds and the state stays in IDLE.
- LOAD: joy_load=0 for exactly 1 tick, then go to SHIFT_LO with bit index k=0.
- SHIFT_LO: joy_clk=0, joy_load=1. On tick, sample the synchronized joy_data into raw bit k, then go to SHIFT_HI.
- SHIFT_HI: joy_clk=1 for 1 tick.
  - If k==31: go to DONE.
  - Otherwise: k <= k+1 and go to SHIFT_LO.
- Bit mapping: raw bit k goes to frame[k]. frame[15:0] is player 1, frame[31:16] is player 2. Output = ~raw (active-high).
- DONE: lasts one clk, not one tick. Pulse frame_done. Then:
  - If DEBOUNCE=0, or frame==prev: update joystick1 and joystick2 atomically in that same clk.
  - Otherwise: outputs hold.
  - In both cases prev <= frame.
  - Go to IDLE and restart the idle counter.
- Frame length: 1 + 64 ticks plus 1 clk. Publish latency for a stable change is at most 2 frame periods.
- enable deasserted mid-frame: the frame completes normally, including any output update, then the block parks in IDLE.
- Outputs never change except in DONE or on reset. A glitch spanning only one frame is never published when DEBOUNCE=1.
- k is 5 bits; there is no wrap beyond 31.

Decomposition:
- Package db15_pkg:
  - state enum {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE}
  - localparams FRAME_BITS=32 and PAD_BITS=16
  - bit-position constants for R/L/D/U.
- Sub-module db15_tick_gen: prescaler producing the one-clk tick strobe, parameterized by CLK_DIV, with sync reset.
- The FSM, shift register, and debounce compare live in the top.

Test Plan (bench uses CLK_DIV=4, POLL_TICKS=8):
- Reset release: first tick gives joy_load=0 for 4 clks. Then exactly 32 rising joy_clk edges, each high phase 4 clks. frame_done pulses once at the end. Outputs stay 0 throughout.
- Adapter model drives constant raw pattern 32'hFFFE_FFF7 (P1 R... bit3=U pressed, P2 bit16 pressed):
  - after frame 1: outputs unchanged;
  - after frame 2: joystick1=16'h0008, joystick2=16'h0001.
- Single-frame glitch: one frame of raw 32'h0000_0000 between stable 32'hFFFF_FFFF frames → outputs remain 0. With DEBOUNCE=0 the glitch frame publishes 16'hFFFF on both.
- Reset asserted at bit k=10 of frame 2 → next clk: joy_clk=0, joy_load=1, outputs 0. The next LOAD starts on the first tick after reset deasserts.
- enable dropped during SHIFT_LO at k=5 → frame finishes and frame_done pulses. No further joy_load low while enable=0. Polling resumes 8 ticks after enable returns high.
